// File: rtl/decode_pkg.sv
// Shared decode definitions: ALU codes, result selects, opcodes, immediate formats
// and the FIFO entry type produced by the decoder.
package decode_pkg;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_SLL   = 5'b00100;
  localparam logic [4:0] ALU_SLT   = 5'b00101;
  localparam logic [4:0] ALU_XOR   = 5'b00110;
  localparam logic [4:0] ALU_SRL   = 5'b00111;
  localparam logic [4:0] ALU_SRA   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01001;
  localparam logic [4:0] ALU_BEQ   = 5'b01010;
  localparam logic [4:0] ALU_BNE   = 5'b01011;
  localparam logic [4:0] ALU_BLT   = 5'b01100;
  localparam logic [4:0] ALU_BGE   = 5'b01101;
  localparam logic [4:0] ALU_BLTU  = 5'b01110;
  localparam logic [4:0] ALU_BGEU  = 5'b01111;
  localparam logic [4:0] ALU_LUI   = 5'b10000;
  localparam logic [4:0] ALU_AUIPC = 5'b10001;
  localparam logic [4:0] ALU_MUL   = 5'b10010;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_CSR = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U,
    IMM_Z
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        csr_write;
    logic [1:0]  result_src;
    logic [4:0]  alu_control;
    logic [2:0]  csr_op;
    logic [2:0]  funct3;
    logic [3:0]  mem_strb;
    logic        illegal;
  } dec_ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_Z:   imm = {27'd0, instr[19:15]};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // Shared funct3 -> ALU op mapping for register and immediate arithmetic
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational RV32 decoder: raw instruction -> dec_ctrl_t FIFO entry.
// Define RV32M_EN to decode the M extension; otherwise funct7=0000001 is illegal.
module instr_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_e   fmt;
  logic       illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl        = '0;
    fmt         = IMM_NONE;
    illegal     = 1'b0;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.funct3 = funct3;

    case (opcode)
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        case (funct7)
          7'b0000000: ctrl.alu_control = base_alu_op(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              ctrl.alu_control = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              ctrl.alu_control = ALU_SRA;
            end else begin
              illegal = 1'b1;
            end
          end
`ifdef RV32M_EN
          7'b0000001: ctrl.alu_control = ALU_MUL + {2'b00, funct3};
`endif
          default: illegal = 1'b1;
        endcase
      end

      OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = base_alu_op(funct3);
        fmt              = IMM_I;
        // Shift-immediates reuse funct7 as the arithmetic/logical selector
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
          illegal = 1'b1;
        end
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) begin
            ctrl.alu_control = ALU_SRA;
          end else if (funct7 != 7'b0000000) begin
            illegal = 1'b1;
          end
        end
      end

      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.mem_strb   = 4'b1111;
        fmt             = IMM_I;
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
          illegal = 1'b1;
        end
      end

      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        fmt            = IMM_S;
        case (funct3)
          3'b000:  ctrl.mem_strb = 4'b0001;
          3'b001:  ctrl.mem_strb = 4'b0011;
          3'b010:  ctrl.mem_strb = 4'b1111;
          default: illegal = 1'b1;
        endcase
      end

      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        fmt         = IMM_B;
        case (funct3)
          3'b000:  ctrl.alu_control = ALU_BEQ;
          3'b001:  ctrl.alu_control = ALU_BNE;
          3'b100:  ctrl.alu_control = ALU_BLT;
          3'b101:  ctrl.alu_control = ALU_BGE;
          3'b110:  ctrl.alu_control = ALU_BLTU;
          3'b111:  ctrl.alu_control = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end

      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        fmt             = IMM_J;
      end

      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        fmt             = IMM_I;
      end

      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_LUI;
        fmt              = IMM_U;
      end

      OP_AUIPC: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_AUIPC;
        fmt              = IMM_U;
      end

      OP_SYSTEM: begin
        // funct3 000/100 are ECALL/EBREAK-space or reserved: not handled here
        if (funct3[1:0] == 2'b00) begin
          illegal = 1'b1;
        end else begin
          ctrl.reg_write  = (instr[11:7] != 5'd0);
          ctrl.csr_write  = !(funct3[1] && instr[19:15] == 5'd0);
          ctrl.result_src = RES_CSR;
          ctrl.csr_op     = funct3;
          fmt             = funct3[2] ? IMM_Z : IMM_I;
        end
      end

      default: illegal = 1'b1;
    endcase

    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end

    ctrl.imm = gen_imm(instr, fmt);

    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.csr_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
    end
    ctrl.illegal = illegal;
  end

endmodule

// File: rtl/instr_decode_buffer.sv
// Decode stage: decodes on entry and queues decoded entries in a DEPTH-deep FIFO.
// Optional M-extension decode is enabled with the RV32M_EN macro.
module instr_decode_buffer
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic             out_mem_read,
  output logic             out_alu_src,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_csr_write,
  output logic [1:0]       out_result_src,
  output logic [4:0]       out_alu_control,
  output logic [2:0]       out_csr_op,
  output logic [2:0]       out_funct3,
  output logic [3:0]       out_mem_strb,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dec_ctrl_t        dec_ctrl;
  dec_ctrl_t        ctrl_arr [DEPTH];
  logic [XLEN-1:0]  pc_arr   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  dec_ctrl_t        head;
  logic [XLEN-1:0]  head_pc;

  instr_decode_comb u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush_i;
  assign pop       = out_valid && out_ready && !flush_i;
  assign count_o   = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      dec_ctrl_t       ctrl_reg;
      logic [XLEN-1:0] pc_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_reg <= '0;
          pc_reg   <= '0;
        end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
          ctrl_reg <= dec_ctrl;
          pc_reg   <= in_pc;
        end
      end

      assign ctrl_arr[gi] = ctrl_reg;
      assign pc_arr[gi]   = pc_reg;
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Empty buffer presents an all-zero bundle so stale entries never leak downstream
  assign head    = out_valid ? ctrl_arr[rd_ptr_reg] : '0;
  assign head_pc = out_valid ? pc_arr[rd_ptr_reg] : '0;

  assign out_pc          = head_pc;
  assign out_rd          = head.rd;
  assign out_rs1         = head.rs1;
  assign out_rs2         = head.rs2;
  assign out_imm         = XLEN'($signed(head.imm));
  assign out_reg_write   = head.reg_write;
  assign out_mem_write   = head.mem_write;
  assign out_mem_read    = head.mem_read;
  assign out_alu_src     = head.alu_src;
  assign out_branch      = head.branch;
  assign out_jump        = head.jump;
  assign out_csr_write   = head.csr_write;
  assign out_result_src  = head.result_src;
  assign out_alu_control = head.alu_control;
  assign out_csr_op      = head.csr_op;
  assign out_funct3      = head.funct3;
  assign out_mem_strb    = head.mem_strb;
  assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Self-checking bench for instr_decode_buffer: directed scenarios plus randomized
// traffic against an instruction-level reference model and a queue of pending entries.
module tb_instr_decode_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [31:0]      in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_pc;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic [31:0]      out_imm;
  logic             out_reg_write, out_mem_write, out_mem_read, out_alu_src;
  logic             out_branch, out_jump, out_csr_write;
  logic [1:0]       out_result_src;
  logic [4:0]       out_alu_control;
  logic [2:0]       out_csr_op, out_funct3;
  logic [3:0]       out_mem_strb;
  logic             out_illegal;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_instr [$];
  logic [31:0] q_pc [$];

  typedef struct {
    logic        ill;
    logic        rw, mw, mr, as, br, jp, cw;
    logic [1:0]  rs;
    logic [4:0]  alu;
    logic [2:0]  cop, f3;
    logic [3:0]  strb;
    logic [31:0] imm;
  } exp_t;

  instr_decode_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_mem_read(out_mem_read), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .out_jump(out_jump), .out_csr_write(out_csr_write), .out_result_src(out_result_src),
    .out_alu_control(out_alu_control), .out_csr_op(out_csr_op), .out_funct3(out_funct3),
    .out_mem_strb(out_mem_strb), .out_illegal(out_illegal), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference decode straight from the ISA tables
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [4:0] arith [8] = '{5'd0, 5'd4, 5'd5, 5'd9, 5'd6, 5'd7, 5'd3, 5'd2};
    logic [4:0] brop  [8] = '{5'd10, 5'd11, 5'd0, 5'd0, 5'd12, 5'd13, 5'd14, 5'd15};
    logic [31:0] imm_i = {{20{i[31]}}, i[31:20]};
    logic [31:0] imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    logic [31:0] imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [31:0] imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    logic [31:0] imm_u = {i[31:12], 12'd0};
    e = '{ill: 0, rw: 0, mw: 0, mr: 0, as: 0, br: 0, jp: 0, cw: 0,
          rs: 0, alu: 0, cop: 0, f3: f3, strb: 0, imm: 0};
    case (op)
      7'h33: begin
        e.rw = 1;
        if (f7 == 7'h00) e.alu = arith[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd8;
`ifdef RV32M_EN
        else if (f7 == 7'h01) e.alu = 5'd18 + {2'b00, f3};
`endif
        else e.ill = 1;
      end
      7'h13: begin
        e.rw = 1; e.as = 1; e.imm = imm_i; e.alu = arith[f3];
        if (f3 == 3'd1 && f7 != 0) e.ill = 1;
        if (f3 == 3'd5 && f7 == 7'h20) e.alu = 5'd8;
        else if (f3 == 3'd5 && f7 != 0) e.ill = 1;
      end
      7'h03: begin
        e.rw = 1; e.mr = 1; e.as = 1; e.rs = 2'b01; e.strb = 4'hF; e.imm = imm_i;
        if (f3 == 3 || f3 == 6 || f3 == 7) e.ill = 1;
      end
      7'h23: begin
        e.mw = 1; e.as = 1; e.imm = imm_s;
        e.strb = (f3 == 0) ? 4'b0001 : (f3 == 1) ? 4'b0011 : 4'b1111;
        if (f3 >= 3) e.ill = 1;
      end
      7'h63: begin
        e.br = 1; e.imm = imm_b; e.alu = brop[f3];
        if (f3 == 2 || f3 == 3) e.ill = 1;
      end
      7'h6F: begin e.rw = 1; e.jp = 1; e.as = 1; e.rs = 2'b10; e.imm = imm_j; end
      7'h67: begin e.rw = 1; e.jp = 1; e.as = 1; e.rs = 2'b10; e.imm = imm_i; end
      7'h37: begin e.rw = 1; e.as = 1; e.alu = 5'd16; e.imm = imm_u; end
      7'h17: begin e.rw = 1; e.as = 1; e.alu = 5'd17; e.imm = imm_u; end
      7'h73: begin
        if (f3 == 0 || f3 == 4) e.ill = 1;
        else begin
          e.rw = (i[11:7] != 0); e.cw = 1; e.rs = 2'b11; e.cop = f3;
          e.imm = (f3 >= 4) ? {27'd0, i[19:15]} : imm_i;
          if ((f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7) && i[19:15] == 0) e.cw = 0;
        end
      end
      default: e.ill = 1;
    endcase
    if (i[1:0] != 2'b11) e.ill = 1;
    if (e.ill) begin
      e.rw = 0; e.mw = 0; e.mr = 0; e.cw = 0; e.br = 0; e.jp = 0;
    end
    return e;
  endfunction

  // Fields other than the suppressed flags carry no meaning on an illegal entry
  function automatic logic [103:0] pack(input exp_t e, input logic [31:0] pc,
                                        input logic [14:0] regs, input bit mask);
    exp_t m = e;
    if (mask && m.ill) begin
      m.as = 0; m.rs = 0; m.alu = 0; m.cop = 0; m.f3 = 0; m.strb = 0; m.imm = 0;
    end
    return {pc, regs, m.imm, m.rw, m.mw, m.mr, m.as, m.br, m.jp, m.cw,
            m.rs, m.alu, m.cop, m.f3, m.strb, m.ill};
  endfunction

  function automatic logic [103:0] exp_vec(input logic [31:0] i, input logic [31:0] pc);
    return pack(model(i), pc, {i[11:7], i[19:15], i[24:20]}, 1'b1);
  endfunction

  function automatic logic [103:0] dut_vec(input bit mask);
    exp_t d;
    d = '{ill: out_illegal, rw: out_reg_write, mw: out_mem_write, mr: out_mem_read,
          as: out_alu_src, br: out_branch, jp: out_jump, cw: out_csr_write,
          rs: out_result_src, alu: out_alu_control, cop: out_csr_op, f3: out_funct3,
          strb: out_mem_strb, imm: out_imm};
    return pack(d, out_pc, {out_rd, out_rs1, out_rs2}, mask);
  endfunction

  // One clock: apply inputs, advance the queue model at the edge, settle 1 time unit after
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit do_push, do_pop;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush_i = fl;
    @(posedge clk);
    if (fl) begin
      q_instr.delete(); q_pc.delete();
    end else begin
      do_pop  = (q_instr.size() != 0) && rdy;
      do_push = v && (q_instr.size() < DEPTH);
      if (do_pop) begin
        void'(q_instr.pop_front()); void'(q_pc.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(ins); q_pc.push_back(pc);
      end
    end
    #1;
    in_valid = 0; flush_i = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && q_instr.size() != 0; k++) step(0, 0, 0, 1, 0);
    checks++;
    if (count_o !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: count=%0d out_valid=%b, required 0/0", count_o, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count_o !== '0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b count=%0d, required 1/0/0",
               in_ready, out_valid, count_o);
    end
    checks++;
    if (dut_vec(0) !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h, required all zero", dut_vec(0));
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    step(1, 32'hFFD0_8293, 32'h0000_0100, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_alu_control !== 5'b00000 || out_alu_src !== 1'b1 ||
        out_imm !== 32'hFFFF_FFFD || out_rd !== 5'd5 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi: valid=%b alu=%b src=%b imm=%h rd=%0d ill=%b, required 1/00000/1/fffffffd/5/0",
               out_valid, out_alu_control, out_alu_src, out_imm, out_rd, out_illegal);
    end
    checks++;
    if (dut_vec(1) !== exp_vec(q_instr[0], q_pc[0])) begin
      errors++;
      $display("FAIL addi_model: got %h required %h", dut_vec(1), exp_vec(q_instr[0], q_pc[0]));
    end
    drain();
  endtask

  task automatic test_fill_wrap();
    for (int k = 0; k < DEPTH; k++) step(1, 32'h0000_0013 | (k << 7), 32'h200 + 4 * k, 0, 0);
    checks++;
    if (in_ready !== 1'b0 || count_o !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL full: in_ready=%b count=%0d, required 0/%0d", in_ready, count_o, DEPTH);
    end
    // Full buffer refuses the push even though a pop happens this cycle
    step(1, 32'h0010_0093, 32'h300, 1, 0);
    checks++;
    if (count_o !== CNT_W'(DEPTH - 1) || out_pc !== q_pc[0]) begin
      errors++;
      $display("FAIL full_pop: count=%0d pc=%h, required %0d/%h", count_o, out_pc, DEPTH - 1, q_pc[0]);
    end
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      checks++;
      if (dut_vec(1) !== exp_vec(q_instr[0], q_pc[0])) begin
        errors++;
        $display("FAIL wrap_head%0d: got %h required %h", k, dut_vec(1), exp_vec(q_instr[0], q_pc[0]));
      end
      step(1, 32'h0000_0033 | (k << 7) | (k << 15), 32'h400 + 4 * k, 1, 0);
      checks++;
      if (count_o !== CNT_W'(DEPTH - 1)) begin
        errors++;
        $display("FAIL wrap_count%0d: got %0d required %0d", k, count_o, DEPTH - 1);
      end
    end
    drain();
  endtask

  task automatic test_branch();
    step(1, 32'hFE00_0CE3, 32'h500, 0, 0);
    step(1, 32'hFE00_2CE3, 32'h504, 0, 0);
    checks++;
    if (out_branch !== 1'b1 || out_alu_control !== 5'b01010 || out_imm !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL beq: br=%b alu=%b imm=%h, required 1/01010/fffffff8",
               out_branch, out_alu_control, out_imm);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (out_illegal !== 1'b1 || out_branch !== 1'b0 || out_pc !== 32'h504) begin
      errors++;
      $display("FAIL br_f3_010: ill=%b br=%b pc=%h, required 1/0/504", out_illegal, out_branch, out_pc);
    end
    drain();
  endtask

  task automatic test_csr();
    step(1, 32'h3000_2073, 32'h600, 0, 0);
    step(1, 32'h3402_D1F3, 32'h604, 0, 0);
    checks++;
    if (out_reg_write !== 1'b0 || out_csr_write !== 1'b0 || out_result_src !== 2'b11) begin
      errors++;
      $display("FAIL csrrs_x0: rw=%b cw=%b rsrc=%b, required 0/0/11",
               out_reg_write, out_csr_write, out_result_src);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (out_imm !== 32'd5 || out_csr_write !== 1'b1 || out_reg_write !== 1'b1 || out_rd !== 5'd3) begin
      errors++;
      $display("FAIL csrrwi: imm=%h cw=%b rw=%b rd=%0d, required 5/1/1/3",
               out_imm, out_csr_write, out_reg_write, out_rd);
    end
    drain();
  endtask

  task automatic test_flush();
    step(1, 32'h0000_0093, 32'h700, 0, 0);
    step(1, 32'h0000_0113, 32'h704, 0, 0);
    step(1, 32'h0000_0193, 32'h708, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || count_o !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b count=%0d ready=%b, required 0/0/1", out_valid, count_o, in_ready);
    end
    step(1, 32'h0010_0213, 32'h70C, 0, 0);
    checks++;
    if (out_pc !== 32'h70C || count_o !== CNT_W'(1)) begin
      errors++;
      $display("FAIL post_flush: pc=%h count=%0d, required 70c/1", out_pc, count_o);
    end
    drain();
  endtask

  task automatic test_mext();
    step(1, 32'h0231_00B3, 32'h800, 0, 0);
`ifdef RV32M_EN
    checks++;
    if (out_alu_control !== 5'b10010 || out_illegal !== 1'b0 || out_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL mul: alu=%b ill=%b rw=%b, required 10010/0/1", out_alu_control, out_illegal, out_reg_write);
    end
`else
    checks++;
    if (out_illegal !== 1'b1 || out_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL mul: ill=%b rw=%b, required 1/0", out_illegal, out_reg_write);
    end
`endif
    drain();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 10);
    if (sel < 10) r[6:0] = ops[sel];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) r[19:15] = 5'd0;
    if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      checks++;
      if (in_ready !== (q_instr.size() < DEPTH) || out_valid !== (q_instr.size() != 0) ||
          count_o !== CNT_W'(q_instr.size())) begin
        errors++;
        $display("FAIL rand_hs%0d: ready=%b valid=%b count=%0d, required count %0d",
                 k, in_ready, out_valid, count_o, q_instr.size());
      end
      if (q_instr.size() != 0) begin
        checks++;
        if (dut_vec(1) !== exp_vec(q_instr[0], q_pc[0])) begin
          errors++;
          $display("FAIL rand_head%0d: instr=%h got %h required %h",
                   k, q_instr[0], dut_vec(1), exp_vec(q_instr[0], q_pc[0]));
        end
      end
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill_wrap();
    test_branch();
    test_csr();
    test_flush();
    test_mext();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_buffer.md
Name: instr_decode_buffer

Overview:
- Decode stage for the 5-stage RV32 core, sitting between fetch and the ID/EX register.
- Accepts raw instructions plus PC over a valid/ready handshake and decodes them on entry.
- Stores the decoded control bundle, register indices and a generated immediate in a parametrised FIFO, and presents the head entry downstream over valid/ready.
- Adds illegal-instruction detection, CSR side-effect suppression and pipeline flush.

Parameters:
- XLEN, 32, datapath width; PC and immediate width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not for override).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all stored and incoming entries
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  buffer can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_pc  out  XLEN  head PC
- out_rd / out_rs1 / out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign/zero-extended immediate
- out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_branch, out_jump, out_csr_write  out  1 each  control flags
- out_result_src  out  2  00 ALU, 01 mem, 10 PC+4, 11 CSR
- out_alu_control  out  5  ALU op code
- out_csr_op  out  3  funct3 of CSR instruction
- out_funct3  out  3  load/store size and sign
- out_mem_strb  out  4  store byte strobe
- out_illegal  out  1  head instruction is illegal
- count_o  out  CNT_W  current occupancy

Behaviour:
- Reset: pointers and count 0; in_ready=1; out_valid=0; every out_* field 0.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. in_ready=(count<DEPTH); there is no pass-through when full, even if a pop happens in the same cycle.
- Latency: an instruction pushed in cycle N is visible on out_* in cycle N+1 at the earliest. Outputs always come from FIFO storage, never from a combinational path off in_*.
- Simultaneous push and pop: count unchanged and both pointers advance, including at count=1.
- Pointers wrap modulo DEPTH.
- out_valid=(count!=0). Head fields stay stable while out_valid&&!out_ready.
- Flush: count and both pointers cleared next edge. A push in the same cycle as flush is dropped. out_valid=0 the cycle after. Flush has priority over push and pop.
- ALU codes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, SLL 00100, SLT 00101, XOR 00110, SRL 00111, SRA 01000, SLTU 01001.
  - BEQ 01010, BNE 01011, BLT 01100, BGE 01101, BLTU 01110, BGEU 01111.
  - LUI 10000, AUIPC 10001.
- Opcode decode:
  - R/I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC and SYSTEM-CSR set the same flags as the existing decoder.
  - Store strobes: SB 0001, SH 0011, SW 1111; loads 1111.
- Immediates (all sign-extended to XLEN): I, S, B (bit0=0), J (bit0=0), U (low 12 bits zero). For CSR with funct3[2]=1, out_imm is the zero-extended 5-bit zimm.
- CSR refinements:
  - rd=x0 forces reg_write=0.
  - CSRRS/CSRRC (and their immediate forms) with rs1/zimm=0 force csr_write=0.
- Illegal when any of:
  - unknown opcode or instr[1:0]≠11;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 ≥011;
  - R-type funct7 other than 0000000, or 0100000 with funct3 other than 000/101;
  - SLLI with funct7≠0, SRLI/SRAI with funct7 other than 0000000/0100000;
  - SYSTEM with funct3 000 or 100.
- An illegal entry has reg_write, mem_write, mem_read, csr_write, branch and jump all 0, illegal=1, and is still queued and popped normally.

Optional Feature:
- Macro: RV32M_EN.
- Defined: opcode 0110011 with funct7=0000001 is decoded as M-extension. funct3 000–111 map to alu_control 10010–11001 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with reg_write=1.
- Undefined: funct7=0000001 is illegal.

Decomposition:
- Package decode_pkg: ALU op localparams, result_src encodings, imm-format enum, opcode localparams, and a packed struct dec_ctrl_t holding all stored fields (FIFO entry type).
- Sub-module instr_decode_comb: pure combinational instruction → dec_ctrl_t, instantiated on the write side. The top level holds the FIFO, counter, handshake and flush.

Test Plan:
- Reset, then push ADDI x5,x1,-3 (0xFFD08293) → next cycle out_valid=1, alu_control=00000, alu_src=1, out_imm=0xFFFFFFFD, rd=5, illegal=0.
- Hold out_ready=0 and push DEPTH instructions → in_ready=0, count_o=DEPTH; then pop and push in the same cycle → count unchanged, order preserved across pointer wrap.
- Push BEQ with offset -8 (0xFE000CE3) → branch=1, alu_control=01010, out_imm=0xFFFFFFF8; push funct3=010 branch → illegal=1, branch=0.
- Push CSRRS x0,mstatus,x0 (0x30002073) → reg_write=0, csr_write=0, result_src=11; push CSRRWI x3,mscratch,5 → out_imm=5, csr_write=1.
- With 2 entries stored, assert flush_i together with in_valid → next cycle out_valid=0, count_o=0, and the flushed-cycle instruction never appears.
- Push MUL x1,x2,x3 (0x023100B3) → with RV32M_EN alu_control=10010, illegal=0; without it illegal=1, reg_write=0.
